// File: rtl/cpu_dbg_pkg.sv
// ============================================================================
//  Module   : cpu_dbg_pkg
//  Purpose  : Shared encodings for the CPU run/step debug controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_dbg_pkg;

    localparam int PC_W = 16;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
//  Module   : key_debounce
//  Purpose  : Raw active-low key -> 2-flop sync -> debounce -> press strobe.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_q;
    logic [CNT_W-1:0] r_cnt;

    // The counter only runs while the synchronized level disagrees with the
    // registered level, so any bounce back restarts the qualification window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_level_q <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= key_n;
            r_sync2   <= r_sync1;
            r_level_q <= r_level;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_level_q & ~r_level;

endmodule

`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
// ============================================================================
//  Module   : cpu_step_ctrl
//  Purpose  : Run/halt/single-step enable generator for the multicycle CPU.
//             Optional PC breakpoint enabled by STEP_CTRL_BREAKPOINT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_step_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int DIV       = 6_000_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter bit START_RUN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            key_mode_n,
    input  logic            key_step_n,
    input  logic [PC_W-1:0] pc_count,
    input  logic [PC_W-1:0] bp_addr,
    output logic            cpu_en,
    output logic            running,
    output logic            at_break,
    output logic [PC_W-1:0] step_count
);

    localparam int DIV_W = $clog2(DIV);
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(DIV - 1);
    localparam state_t c_reset_state = START_RUN ? ST_RUN : ST_HALT;

    state_t            r_state;
    state_t            w_state_next;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  w_div_next;
    logic              r_cpu_en;
    logic              w_pulse;
    logic [PC_W-1:0]   r_step_count;
    logic              w_mode_press;
    logic              w_step_press;
    logic              w_tc;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_key_mode (
        .clk   (clk),
        .reset (reset),
        .key_n (key_mode_n),
        .press (w_mode_press)
    );

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_key_step (
        .clk   (clk),
        .reset (reset),
        .key_n (key_step_n),
        .press (w_step_press)
    );

    assign w_tc = (r_div == c_div_last);

`ifdef STEP_CTRL_BREAKPOINT_EN
    logic r_armed;
    logic w_armed_next;
    logic w_bp_hit;

    assign w_bp_hit = r_armed && (pc_count == bp_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b1;
        end else begin
            r_armed <= w_armed_next;
        end
    end
`else
    logic w_unused_bp;
    assign w_unused_bp = ^{pc_count, bp_addr};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_reset_state;
            r_div        <= '0;
            r_cpu_en     <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_div        <= w_div_next;
            r_cpu_en     <= w_pulse;
            r_step_count <= r_step_count + {{(PC_W-1){1'b0}}, r_cpu_en};
        end
    end

    // Divider is held at zero outside RUN so entry always starts a full period.
    always_comb begin
        w_state_next = r_state;
        w_div_next   = '0;
        w_pulse      = 1'b0;
`ifdef STEP_CTRL_BREAKPOINT_EN
        w_armed_next = r_armed;
`endif
        case (r_state)
            ST_HALT, ST_BREAK: begin
                if (w_mode_press) begin
                    w_state_next = ST_RUN;
                end else if (w_step_press) begin
                    w_state_next = ST_STEP;
                end
            end
            ST_STEP: begin
                w_pulse      = 1'b1;
                w_state_next = ST_HALT;
            end
            ST_RUN: begin
                if (w_mode_press) begin
                    w_state_next = ST_HALT;
                end else if (w_tc) begin
`ifdef STEP_CTRL_BREAKPOINT_EN
                    if (w_bp_hit) begin
                        w_state_next = ST_BREAK;
                        w_armed_next = 1'b0;
                    end else begin
                        w_pulse      = 1'b1;
                        w_armed_next = 1'b1;
                    end
`else
                    w_pulse = 1'b1;
`endif
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_HALT;
            end
        endcase
    end

    assign cpu_en     = r_cpu_en;
    assign running    = (r_state == ST_RUN);
    assign step_count = r_step_count;
`ifdef STEP_CTRL_BREAKPOINT_EN
    assign at_break   = (r_state == ST_BREAK);
`else
    assign at_break   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
// ============================================================================
//  Module   : tb_cpu_step_ctrl
//  Purpose  : Self-checking bench for cpu_step_ctrl (DIV=4, DB_CYCLES=3).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_step_ctrl;

    localparam int DIV_T = 4;
    localparam int DB_T  = 3;
    localparam int NR    = 3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_mode_n = 1'b1;
    logic        key_step_n = 1'b1;
    logic [15:0] pc_count = 16'h0000;
    logic [15:0] bp_addr = 16'hFFFF;
    logic        cpu_en;
    logic        running;
    logic        at_break;
    logic [15:0] step_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        mode_n;
        logic        step_n;
        logic        exp_en;
        logic        exp_run;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vt[14];

    bit raw_k[2][0:NR];
    bit str_k[2][0:NR+8];
    bit en_e[0:NR];
    bit run_e[0:NR];

    cpu_step_ctrl #(
        .DIV       (DIV_T),
        .DB_CYCLES (DB_T),
        .START_RUN (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_mode_n (key_mode_n),
        .key_step_n (key_step_n),
        .pc_count   (pc_count),
        .bp_addr    (bp_addr),
        .cpu_en     (cpu_en),
        .running    (running),
        .at_break   (at_break),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int p, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at point %0d: got %h want %h", nm, p, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release lands 1 time unit after an edge; that instant is point 0.
    task automatic do_reset();
        reset      = 1'b1;
        key_mode_n = 1'b1;
        key_step_n = 1'b1;
        pc_count   = 16'h0000;
        bp_addr    = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int          st;
        int          r_entry;
        int          p;
        int          len;
        int          cnt_exp;
        bit          lv;
        bit          db;
        bit          m;
        bit          s;
        logic        e_en;
        logic        e_run;
        logic [15:0] e_cnt;

        // reset state and free-run pulses on points 4, 8, 12
        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd1};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd2};
        vt[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd2};
        vt[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd2};
        vt[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd2};
        vt[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd3};

        do_reset();
        chk("rst_at_break", 0, {15'd0, at_break}, 16'd0);
        for (int i = 0; i < 14; i++) begin
            chk("tbl_cpu_en", i, {15'd0, cpu_en}, {15'd0, vt[i].exp_en});
            chk("tbl_running", i, {15'd0, running}, {15'd0, vt[i].exp_run});
            chk("tbl_step_count", i, step_count, vt[i].exp_cnt);
            key_mode_n = vt[i].mode_n;
            key_step_n = vt[i].step_n;
            tick();
        end

        // held mode press, glitch, single step, simultaneous mode+step
        do_reset();
        for (int q = 0; q <= 100; q++) begin
            e_en  = (q == 4 || q == 67 || q == 95 || q == 99);
            e_run = (q < 6) || (q >= 91);
            e_cnt = (q <= 4) ? 16'd0 : (q <= 67) ? 16'd1 : (q <= 95) ? 16'd2 :
                    (q <= 99) ? 16'd3 : 16'd4;
            chk("seq_cpu_en", q, {15'd0, cpu_en}, {15'd0, e_en});
            chk("seq_running", q, {15'd0, running}, {15'd0, e_run});
            chk("seq_step_count", q, step_count, e_cnt);
            key_mode_n = !((q <= 9) || q == 45 || q == 46 || (q >= 85 && q <= 92));
            key_step_n = !((q >= 60 && q <= 69) || (q >= 85 && q <= 92));
            tick();
        end

        // reset in the middle of a pulse
        do_reset();
        repeat (4) tick();
        chk("pre_rst_cpu_en", 4, {15'd0, cpu_en}, 16'd1);
        reset = 1'b1;
        #1;
        chk("rst_pulse_cpu_en", 4, {15'd0, cpu_en}, 16'd0);
        chk("rst_pulse_count", 4, step_count, 16'd0);

        // reset with the divider at 2 after one pulse
        do_reset();
        repeat (6) tick();
        chk("pre_rst_count", 6, step_count, 16'd1);
        reset = 1'b1;
        #1;
        chk("rst_div_cpu_en", 6, {15'd0, cpu_en}, 16'd0);
        chk("rst_div_running", 6, {15'd0, running}, 16'd1);
        chk("rst_div_count", 6, step_count, 16'd0);
        do_reset();
        for (int q = 0; q <= 4; q++) begin
            chk("post_rst_cpu_en", q, {15'd0, cpu_en}, {15'd0, (q == 4)});
            tick();
        end

        // breakpoint at the first terminal count, resume executes it once
        do_reset();
        bp_addr = 16'h0005;
        for (int q = 0; q <= 21; q++) begin
`ifdef STEP_CTRL_BREAKPOINT_EN
            if (q == 4) begin
                chk("bp_hit_cpu_en", q, {15'd0, cpu_en}, 16'd0);
                chk("bp_hit_at_break", q, {15'd0, at_break}, 16'd1);
                chk("bp_hit_running", q, {15'd0, running}, 16'd0);
            end
            if (q == 12) begin
                chk("bp_resume_running", q, {15'd0, running}, 16'd1);
                chk("bp_resume_at_break", q, {15'd0, at_break}, 16'd0);
            end
            if (q == 16) chk("bp_resume_pulse", q, {15'd0, cpu_en}, 16'd1);
            if (q == 20) begin
                chk("bp_rearm_cpu_en", q, {15'd0, cpu_en}, 16'd0);
                chk("bp_rearm_at_break", q, {15'd0, at_break}, 16'd1);
            end
            if (q == 21) chk("bp_count", q, step_count, 16'd1);
`else
            if (q == 4) begin
                chk("nobp_cpu_en", q, {15'd0, cpu_en}, 16'd1);
                chk("nobp_at_break", q, {15'd0, at_break}, 16'd0);
            end
            if (q == 12) chk("nobp_halted", q, {15'd0, running}, 16'd0);
            if (q == 21) chk("nobp_count", q, step_count, 16'd2);
`endif
            if (q == 3) pc_count = 16'h0005;
            key_mode_n = !(q >= 6 && q <= 13);
            tick();
        end

        // randomized keys: alternating segments, some shorter than DB_T
        for (int k = 0; k < 2; k++) begin
            p  = 0;
            lv = 1'b1;
            db = 1'b1;
            while (p <= NR) begin
                if ($urandom_range(0, 1) == 0) len = $urandom_range(1, DB_T - 1);
                else                           len = $urandom_range(DB_T, DB_T + 25);
                if (lv != db && len >= DB_T) begin
                    db = lv;
                    if (!lv && p + 3 + DB_T <= NR + 8) str_k[k][p + 3 + DB_T] = 1'b1;
                end
                for (int j = 0; j < len; j++)
                    if (p + j <= NR) raw_k[k][p + j] = lv;
                p  = p + len;
                lv = !lv;
            end
        end

        // reference: 0=halt 1=run 2=step; run pulses every DIV_T edges from entry
        st       = 1;
        r_entry  = 0;
        run_e[0] = 1'b1;
        for (int e = 1; e <= NR; e++) begin
            m = str_k[0][e];
            s = str_k[1][e];
            case (st)
                0: begin
                    if (m) begin
                        st      = 1;
                        r_entry = e;
                    end else if (s) begin
                        st = 2;
                    end
                end
                2: begin
                    en_e[e] = 1'b1;
                    st      = 0;
                end
                default: begin
                    if (m) st = 0;
                    else if ((e - r_entry) % DIV_T == 0) en_e[e] = 1'b1;
                end
            endcase
            run_e[e] = (st == 1);
        end

        do_reset();
        cnt_exp = 0;
        for (int q = 0; q <= NR; q++) begin
            chk("rnd_cpu_en", q, {15'd0, cpu_en}, {15'd0, en_e[q]});
            chk("rnd_running", q, {15'd0, running}, {15'd0, run_e[q]});
            chk("rnd_step_count", q, step_count, cnt_exp[15:0]);
            chk("rnd_at_break", q, {15'd0, at_break}, 16'd0);
            if (en_e[q]) cnt_exp++;
            key_mode_n = raw_k[0][q];
            key_step_n = raw_k[1][q];
            pc_count   = 16'($urandom_range(0, 16'hFFFE));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
